// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared constants for the matrix receive path: FSM state encoding, the
// error codes reported on error_type, the default matrix dimension limit and
// a helper that validates a received dimension byte.
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int MATRIX_MAX_DIM = 5;

  // Parser FSM states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_N    = 2'd1;
  localparam logic [1:0] ST_GET_ELEM = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  // Status codes reported on error_type
  localparam logic [2:0] ERR_OK      = 3'b000;
  localparam logic [2:0] ERR_DIM     = 3'b001;
  localparam logic [2:0] ERR_RANGE   = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT = 3'b100;
  localparam logic [2:0] ERR_ABORT   = 3'b101;

  // A dimension byte is legal when it lies in 1..max_dim.
  function automatic logic dim_ok(input logic [7:0] v, input int max_dim);
    return (v != 8'd0) && (int'(v) <= max_dim);
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// -----------------------------------------------------------------------------
// rx_gap_timer
// Counts clock cycles since the last received byte while enabled.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : a byte arrived this cycle; the count restarts
//   enable     : parser is mid-message; when low the count is held at zero
//   expired    : GAP_CYC cycles have passed since the last restart
// The count reads k in the k-th cycle after a restart, so expired is seen in
// cycle GAP_CYC-1 and the parser's registered reaction lands exactly GAP_CYC
// cycles after the strobe. GAP_CYC must be at least 2.
// -----------------------------------------------------------------------------
module rx_gap_timer #(
  parameter int GAP_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(GAP_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A strobe always restarts the count, even in the cycle the parser leaves
  // IDLE, so the first gap after the m byte is measured correctly.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (restart)           cnt_d = CNT_W'(1);
    else if (!enable)      cnt_d = '0;
    else if (cnt_q < LIMIT) cnt_d = cnt_q + CNT_W'(1);
  end

  assign expired = enable && !restart && (cnt_q >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/matrix_rx_parser.sv
// -----------------------------------------------------------------------------
// matrix_rx_parser
// Parses a UART byte stream "m, n, m*n elements (row-major)" into element
// writes for an external matrix store, with dimension/range checking, an
// inter-byte timeout and a synchronous abort.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_data, rx_valid   : received byte and its single-cycle strobe
//   abort               : abandon the matrix in progress
//   val_min, val_max    : inclusive element bounds, sampled with the m byte
//   wr_en/addr/data     : element write port (addr = row*MAX_DIM + col)
//   mat_m, mat_n        : dimensions of the last matrix that completed cleanly
//   busy, done          : parser active / one-cycle completion pulse
//   error_type          : status of the last matrix, held until the next m byte
// -----------------------------------------------------------------------------
module matrix_rx_parser
  import matrix_pkg::*;
#(
  parameter  int MAX_DIM = MATRIX_MAX_DIM,
  parameter  int DATA_W  = 4,
  parameter  int GAP_CYC = 1_000_000,
  localparam int ADDR_W  = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              abort,
  input  logic [DATA_W-1:0] val_min,
  input  logic [DATA_W-1:0] val_max,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        mat_m,
  output logic [3:0]        mat_n,
  output logic              busy,
  output logic              done,
  output logic [2:0]        error_type
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  logic [1:0]        state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0] vmin_q, vmin_d, vmax_q, vmax_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [3:0]        mat_m_q, mat_m_d, mat_n_q, mat_n_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;

  logic timer_en, gap_expired;
  logic elem_in_range, last_col, last_row;
  logic [ADDR_W-1:0] elem_addr;

  assign timer_en = (state_q != ST_IDLE);

  rx_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (rx_valid),
    .enable  (timer_en),
    .expired (gap_expired)
  );

  // Bounds are zero-extended to the byte width so a byte above 2**DATA_W-1
  // is rejected rather than silently truncated into range.
  assign elem_in_range = (rx_data >= 8'(vmin_q)) && (rx_data <= 8'(vmax_q));
  assign last_col      = (col_q == n_q - DIM_W'(1));
  assign last_row      = (row_q == m_q - DIM_W'(1));
  assign elem_addr     = ADDR_W'(int'(row_q) * MAX_DIM + int'(col_q));

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    vmin_d    = vmin_q;
    vmax_d    = vmax_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mat_m_d   = mat_m_q;
    mat_n_d   = mat_n_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Abort wins over a byte arriving in the same cycle.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      err_d   = ERR_ABORT;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          err_d  = ERR_OK;
          vmin_d = val_min;
          vmax_d = val_max;
          if (dim_ok(rx_data, MAX_DIM)) begin
            m_d     = DIM_W'(rx_data);
            state_d = ST_GET_N;
          end else begin
            err_d   = ERR_DIM;
            done_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_GET_N: begin
          if (rx_valid) begin
            if (dim_ok(rx_data, MAX_DIM)) begin
              n_d     = DIM_W'(rx_data);
              row_d   = '0;
              col_d   = '0;
              state_d = ST_GET_ELEM;
            end else begin
              err_d   = ERR_DIM;
              done_d  = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (gap_expired) begin
            err_d   = ERR_TIMEOUT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GET_ELEM: begin
          if (rx_valid) begin
            if (!elem_in_range) begin
              err_d   = ERR_RANGE;
              done_d  = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = elem_addr;
              wr_data_d = rx_data[DATA_W-1:0];
              if (last_col) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
                if (last_row) begin
                  done_d  = 1'b1;
                  mat_m_d = 4'(m_q);
                  mat_n_d = 4'(n_q);
                  state_d = ST_IDLE;
                end
              end else begin
                col_d = col_q + DIM_W'(1);
              end
            end
          end else if (gap_expired) begin
            err_d   = ERR_TIMEOUT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DRAIN: if (gap_expired) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      n_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      vmin_q    <= '0;
      vmax_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mat_m_q   <= '0;
      mat_n_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      n_q       <= n_d;
      row_q     <= row_d;
      col_q     <= col_d;
      vmin_q    <= vmin_d;
      vmax_q    <= vmax_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mat_m_q   <= mat_m_d;
      mat_n_q   <= mat_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign mat_m      = mat_m_q;
  assign mat_n      = mat_n_q;
  assign done       = done_q;
  assign error_type = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_rx_parser.sv
// -----------------------------------------------------------------------------
// tb_matrix_rx_parser
// Self-checking bench for matrix_rx_parser. A table of matrix transactions is
// expanded into byte streams; expected writes and done records are queued as
// stimulus is built and compared when the DUT emits them. Hand sequences
// cover timeout latency, drain timer restart, abort and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_matrix_rx_parser;

  localparam int MAX_DIM = 5;
  localparam int DATA_W  = 4;
  localparam int GAP_CYC = 16;
  localparam int ADDR_W  = $clog2(MAX_DIM * MAX_DIM);

  localparam logic [2:0] E_OK = 3'b000, E_DIM = 3'b001, E_RANGE = 3'b011,
                         E_TMO = 3'b100, E_ABT = 3'b101;

  logic              clk, rst_n, rx_valid, abort;
  logic [7:0]        rx_data;
  logic [DATA_W-1:0] val_min, val_max;
  logic              wr_en, busy, done;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        mat_m, mat_n;
  logic [2:0]        error_type;

  matrix_rx_parser #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .abort(abort), .val_min(val_min), .val_max(val_max),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mat_m(mat_m), .mat_n(mat_n), .busy(busy), .done(done),
    .error_type(error_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { logic [2:0] err; logic [3:0] m; logic [3:0] n; } done_t;
  typedef struct {
    logic [7:0] m; logic [7:0] n; logic [3:0] vmin; logic [3:0] vmax;
    int first; int step; logic [2:0] exp_err;
  } vec_t;

  wr_t   wr_q[$];
  done_t dn_q[$];
  wr_t   wr_e;
  done_t dn_e;
  int    n_checks = 0, n_fail = 0, done_seen = 0, done_exp = 0;
  logic [3:0] last_m = 4'd0, last_n = 4'd0;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard side: compare every write and done pulse against the queues.
  always @(negedge clk) if (rst_n) begin
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
      end else begin
        wr_e = wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(wr_e.addr));
        check("wr_data", 32'(wr_data), 32'(wr_e.data));
      end
    end
    if (done) begin
      done_seen++;
      if (dn_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got error_type %0d, expected no done", error_type);
      end else begin
        dn_e = dn_q.pop_front();
        check("done_error_type", 32'(error_type), 32'(dn_e.err));
        check("done_mat_m", 32'(mat_m), 32'(dn_e.m));
        check("done_mat_n", 32'(mat_n), 32'(dn_e.n));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = ADDR_W'(addr); w.data = DATA_W'(data);
    wr_q.push_back(w);
  endtask

  task automatic push_done(input logic [2:0] err);
    done_t d;
    d.err = err; d.m = last_m; d.n = last_n;
    dn_q.push_back(d);
    done_exp++;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_seen < done_exp && k < 8) begin tick(1); k++; end
    check(name, 32'(done_seen), 32'(done_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_mat_m"}, 32'(mat_m), 0);
    check({tag, "_mat_n"}, 32'(mat_n), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error_type"}, 32'(error_type), 0);
  endtask

  // Expand one table entry into bytes, queue expectations, drive, verify.
  task automatic run_vec(input vec_t v);
    logic [7:0] bq[$];
    int val, k;
    logic stop;
    val_min = v.vmin; val_max = v.vmax;
    bq.push_back(v.m);
    if (v.m == 0 || int'(v.m) > MAX_DIM) begin
      bq.push_back(8'h01); bq.push_back(8'h02);
    end else begin
      bq.push_back(v.n);
      if (v.n == 0 || int'(v.n) > MAX_DIM) begin
        bq.push_back(8'h01); bq.push_back(8'h02);
      end else begin
        stop = 1'b0; k = 0;
        for (int r = 0; r < int'(v.m) && !stop; r++)
          for (int c = 0; c < int'(v.n) && !stop; c++) begin
            val = (v.first + k * v.step) & 255;
            k++;
            bq.push_back(8'(val));
            if (val < int'(v.vmin) || val > int'(v.vmax)) begin
              stop = 1'b1;
              bq.push_back(8'h01);
            end else begin
              push_wr(r * MAX_DIM + c, val);
            end
          end
      end
    end
    if (v.exp_err == E_OK) begin last_m = v.m[3:0]; last_n = v.n[3:0]; end
    push_done(v.exp_err);
    for (int i = 0; i < bq.size(); i++) begin
      send(bq[i]);
      // Bounds moved after the m byte must not affect this matrix.
      if (i == 0) begin val_min = 4'hF; val_max = 4'h0; end
    end
    wait_done("vec_done");
    tick((v.exp_err == E_OK) ? 2 : GAP_CYC + 4);
    check("vec_busy_idle", 32'(busy), 0);
    check("vec_error_hold", 32'(error_type), 32'(v.exp_err));
    check("vec_writes_drained", 32'(wr_q.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    logic found;

    vecs[0]  = '{8'd2, 8'd3, 4'd0, 4'd9,  1,  1, E_OK};    // 2x3, data 1..6
    vecs[1]  = '{8'd6, 8'd1, 4'd0, 4'd9,  0,  0, E_DIM};   // m too large
    vecs[2]  = '{8'd1, 8'd1, 4'd0, 4'd15, 7,  0, E_OK};    // 1x1 after drain
    vecs[3]  = '{8'd5, 8'd5, 4'd3, 4'd6,  6,  0, E_OK};    // full 5x5 at max bound
    vecs[4]  = '{8'd2, 8'd2, 4'd4, 4'd9,  4,  0, E_OK};    // elements at min bound
    vecs[5]  = '{8'd2, 8'd2, 4'd0, 4'd9,  3,  9, E_RANGE}; // 3 then 12
    vecs[6]  = '{8'd2, 8'd2, 4'd2, 4'd9,  1,  1, E_RANGE}; // below min at first
    vecs[7]  = '{8'd3, 8'd0, 4'd0, 4'd9,  0,  0, E_DIM};   // n zero
    vecs[8]  = '{8'd0, 8'd1, 4'd0, 4'd9,  0,  0, E_DIM};   // m zero
    vecs[9]  = '{8'd3, 8'd2, 4'd0, 4'd5,  4,  1, E_RANGE}; // 4,5 then 6
    vecs[10] = '{8'd5, 8'd1, 4'd0, 4'd15, 15, 0, E_OK};    // single column
    vecs[11] = '{8'd1, 8'd5, 4'd0, 4'd15, 16, 0, E_RANGE}; // 16 not truncated

    rst_n = 1'b0; rx_valid = 1'b0; abort = 1'b0; rx_data = 8'h00;
    val_min = '0; val_max = '0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Timeout: done must land exactly GAP_CYC cycles after the last strobe.
    val_min = 4'd0; val_max = 4'd9;
    push_wr(0, 1);
    push_done(E_TMO);
    send(8'd3); send(8'd3); send(8'd1);
    k = 1; found = 1'b0;
    while (!found && k <= GAP_CYC + 5) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin @(posedge clk); #1; k++; end
    end
    @(posedge clk); #1;
    check("timeout_seen", 32'(found), 1);
    check("timeout_latency", 32'(k), 32'(GAP_CYC));
    check("timeout_busy", 32'(busy), 0);
    check("timeout_error", 32'(error_type), 32'(E_TMO));

    // Drain: a byte during drain restarts the quiet period.
    push_done(E_DIM);
    send(8'd0);
    wait_done("drain_done");
    tick(GAP_CYC - 4);
    send(8'h05);
    tick(GAP_CYC - 4);
    check("drain_restart_busy", 32'(busy), 1);
    tick(8);
    check("drain_exit_busy", 32'(busy), 0);
    check("drain_error_hold", 32'(error_type), 32'(E_DIM));

    // Abort together with an element byte: no write for that byte.
    push_wr(0, 1);
    send(8'd2); send(8'd2); send(8'd1);
    push_done(E_ABT);
    rx_data = 8'd2; rx_valid = 1'b1; abort = 1'b1;
    tick(1);
    rx_valid = 1'b0; abort = 1'b0;
    wait_done("abort_elem_done");
    tick(1);
    check("abort_busy", 32'(busy), 0);
    check("abort_error", 32'(error_type), 32'(E_ABT));
    check("abort_writes", 32'(wr_q.size()), 0);

    // Abort in GET_N, then abort in IDLE which must do nothing.
    send(8'd4);
    push_done(E_ABT);
    abort = 1'b1; tick(1); abort = 1'b0;
    wait_done("abort_getn_done");
    abort = 1'b1; tick(3); abort = 1'b0; tick(1);
    check("abort_idle_busy", 32'(busy), 0);
    check("abort_idle_done_count", 32'(done_seen), 32'(done_exp));

    // Reset mid element stream.
    push_wr(0, 1); push_wr(1, 2);
    send(8'd3); send(8'd3); send(8'd1); send(8'd2);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    last_m = 4'd0; last_n = 4'd0;
    tick(GAP_CYC + 4);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done_count", 32'(done_seen), 32'(done_exp));
    push_wr(0, 0);
    last_m = 4'd1; last_n = 4'd1;
    push_done(E_OK);
    send(8'd1); send(8'd1); send(8'd0);
    wait_done("after_reset_done");
    tick(2);
    check("after_reset_mat_m", 32'(mat_m), 1);
    check("after_reset_mat_n", 32'(mat_n), 1);
    check("final_wr_queue", 32'(wr_q.size()), 0);
    check("final_done_queue", 32'(dn_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
